// File: rtl/arm_pose_sequencer.sv
// Teach-and-playback pose sequencer feeding the 4-channel servo PWM stage.
// Optional `SEQ_LOOP_EN: playback wraps to slot 0 after the last dwell instead of stopping.
module arm_pose_sequencer #(
    parameter int DEPTH        = 8,
    parameter int PW_MIN       = 50000,
    parameter int PW_MAX       = 75000,
    parameter int CENTER       = 62500,
    parameter int STEP         = 200,
    parameter int DWELL_FRAMES = 25
) (
    input  logic                     CLOCK_50,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [67:0]              live_pw,
    input  logic                     cmd_store,
    input  logic                     cmd_play,
    input  logic                     cmd_stop,
    input  logic                     cmd_clear,
    output logic [67:0]              pw_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pose_count,
    output logic [$clog2(DEPTH)-1:0] cur_index,
    output logic                     full,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int NJ = 4;
    localparam int PW = 17;
    localparam int XW = PW + 1;
    localparam int DW = (DWELL_FRAMES < 2) ? 1 : $clog2(DWELL_FRAMES + 1);

    localparam logic [XW-1:0] C_MIN    = XW'(PW_MIN);
    localparam logic [XW-1:0] C_MAX    = XW'(PW_MAX);
    localparam logic [XW-1:0] C_STEP   = XW'(STEP);
    localparam logic [PW-1:0] C_CENTER = PW'(CENTER);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RAMP, S_DWELL} state_t;

    function automatic logic [PW-1:0] f_clamp(input logic [XW-1:0] v);
        if (v < C_MIN)      return C_MIN[PW-1:0];
        else if (v > C_MAX) return C_MAX[PW-1:0];
        else                return v[PW-1:0];
    endfunction

    // Widened to XW bits so the +/- STEP never wraps before clamping.
    function automatic logic [PW-1:0] f_step(input logic [PW-1:0] pw, input logic [PW-1:0] tgt);
        logic [XW-1:0] p;
        logic [XW-1:0] t;
        p = {1'b0, pw};
        t = {1'b0, tgt};
        if (t >= p) return (t - p <= C_STEP) ? tgt : f_clamp(p + C_STEP);
        else        return (p - t <= C_STEP) ? tgt : f_clamp(p - C_STEP);
    endfunction

    state_t              r_state;
    logic [NJ*PW-1:0]    r_pw;
    logic [NJ*PW-1:0]    r_target;
    logic [NJ*PW-1:0]    r_mem [DEPTH];
    logic [AW:0]         r_pose_count;
    logic [AW-1:0]       r_cur_index;
    logic [DW-1:0]       r_dwell_cnt;
    logic                r_busy;
    logic                r_err;

    state_t              w_state_nxt;
    logic [NJ*PW-1:0]    w_live_cl;
    logic [NJ*PW-1:0]    w_step;
    logic [AW:0]         w_pc_m1;
    logic [AW-1:0]       w_idx_nxt;
    logic                w_full;
    logic                w_at_tgt;
    logic                w_last;
    logic                w_err;
    logic                w_we;
    logic                w_clear;
    logic                w_pw_live;
    logic                w_pw_step;
    logic                w_load_tgt;
    logic                w_dwell_clr;
    logic                w_dwell_inc;

    for (genvar j = 0; j < NJ; j++) begin : g_joint
        assign w_live_cl[j*PW +: PW] = f_clamp({1'b0, live_pw[j*PW +: PW]});
        assign w_step[j*PW +: PW]    = f_step(r_pw[j*PW +: PW], r_target[j*PW +: PW]);
    end

    assign w_full   = (r_pose_count == (AW+1)'(DEPTH));
    assign w_at_tgt = (w_step == r_target);
    assign w_pc_m1  = r_pose_count - (AW+1)'(1);
    assign w_last   = (r_cur_index == w_pc_m1[AW-1:0]);

    always_ff @(posedge CLOCK_50) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_cur_index;
        w_err       = 1'b0;
        w_we        = 1'b0;
        w_clear     = 1'b0;
        w_pw_live   = 1'b0;
        w_pw_step   = 1'b0;
        w_load_tgt  = 1'b0;
        w_dwell_clr = 1'b0;
        w_dwell_inc = 1'b0;
        if (r_state == S_IDLE) begin
            w_pw_live = frame_tick;
            // stop > play > store > clear; stop itself has nothing to do here
            if (cmd_stop) begin
                w_err = 1'b0;
            end else if (cmd_play) begin
                if (r_pose_count == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end
            end else if (cmd_store) begin
                if (w_full) w_err = 1'b1;
                else        w_we  = 1'b1;
            end else if (cmd_clear) begin
                w_clear = 1'b1;
            end
        end else if (cmd_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            w_err = cmd_play | cmd_store | cmd_clear;
            case (r_state)
                S_LOAD: begin
                    w_load_tgt  = 1'b1;
                    w_state_nxt = S_RAMP;
                end
                S_RAMP: begin
                    if (frame_tick) begin
                        w_pw_step = 1'b1;
                        if (w_at_tgt) begin
                            w_dwell_clr = 1'b1;
                            w_state_nxt = S_DWELL;
                        end
                    end
                end
                S_DWELL: begin
                    if (frame_tick) begin
                        w_dwell_inc = 1'b1;
                        if (int'(r_dwell_cnt) + 1 >= DWELL_FRAMES) begin
                            if (w_last) begin
`ifdef SEQ_LOOP_EN
                                w_idx_nxt   = '0;
                                w_state_nxt = S_LOAD;
`else
                                w_state_nxt = S_IDLE;
`endif
                            end else begin
                                w_idx_nxt   = r_cur_index + AW'(1);
                                w_state_nxt = S_LOAD;
                            end
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_pw         <= {NJ{C_CENTER}};
            r_target     <= {NJ{C_CENTER}};
            r_pose_count <= '0;
            r_cur_index  <= '0;
            r_dwell_cnt  <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err       <= w_err;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_cur_index <= w_idx_nxt;
            if (w_pw_live)      r_pw <= w_live_cl;
            else if (w_pw_step) r_pw <= w_step;
            if (w_we)           r_pose_count <= r_pose_count + (AW+1)'(1);
            else if (w_clear)   r_pose_count <= '0;
            if (w_load_tgt)     r_target <= r_mem[r_cur_index];
            if (w_dwell_clr)      r_dwell_cnt <= '0;
            else if (w_dwell_inc) r_dwell_cnt <= r_dwell_cnt + DW'(1);
        end
    end

    // Pose memory has no reset; only slots below pose_count are ever read.
    always_ff @(posedge CLOCK_50) begin
        if (w_we) r_mem[r_pose_count[AW-1:0]] <= w_live_cl;
    end

    assign pw_out     = r_pw;
    assign busy       = r_busy;
    assign pose_count = r_pose_count;
    assign cur_index  = r_cur_index;
    assign full       = w_full;
    assign err        = r_err;

endmodule

// File: doc/arm_pose_sequencer.md
Name: arm_pose_sequencer

Overview:
Teach-and-playback stage directly upstream of the 4-channel servo PWM generator. Records up to DEPTH poses, each holding four 17-bit pulse widths in 50 MHz clock counts, captured from the live jog values. On command it replays the stored poses in order, slew-limited to STEP counts per 20 ms frame. It drives the pulse-width bus consumed by the PWM stage.

Parameters:
DEPTH, 8, number of pose slots (power of 2, at least 2)
PW_MIN, 50000, lowest legal pulse width in clocks (1.0 ms)
PW_MAX, 75000, highest legal pulse width in clocks (1.5 ms)
CENTER, 62500, reset pulse width in clocks
STEP, 200, maximum change per joint per frame
DWELL_FRAMES, 25, frames held at each reached pose (0.5 s)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse at start of each 20 ms PWM frame
live_pw  in  68  jog pulse widths; joint j occupies [17j+16:17j]
cmd_store  in  1  pulse: append live_pw as a new pose
cmd_play  in  1  pulse: start playback from slot 0
cmd_stop  in  1  pulse: abort playback, hold current pw_out
cmd_clear  in  1  pulse: empty pose memory (IDLE only)
pw_out  out  68  pulse widths to PWM stage, same packing as live_pw
busy  out  1  high while not IDLE
pose_count  out  $clog2(DEPTH)+1  number of stored poses
cur_index  out  $clog2(DEPTH)  slot being approached or dwelt on
full  out  1  pose_count == DEPTH
err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset:
  - pw_out = 4 × CENTER; pose_count = 0; cur_index = 0; busy = 0; err = 0; state = IDLE.
  - Memory contents are don't-care.
- Clamping:
  - Every value written to memory or to pw_out is clamped to [PW_MIN, PW_MAX].
  - Arithmetic is at least 18 bits wide, so no wrap below 0 or above 2^17.
- Command priority when several commands arrive in the same cycle: stop > play > store > clear. Only the highest-priority command acts; the others are dropped silently.
- IDLE:
  - On each frame_tick, pw_out <= clamp(live_pw), giving passthrough jog at frame rate.
  - cmd_store:
    - If not full: write clamp(live_pw) to slot pose_count; pose_count increments the next cycle.
    - If full: err pulse, no write.
  - cmd_clear: pose_count <= 0.
  - cmd_play:
    - If pose_count == 0: err pulse, stay IDLE.
    - Otherwise: cur_index <= 0, go to LOAD.
- LOAD (1 cycle): read slot cur_index into the target register, go to RAMP. Memory read latency is 1 cycle; LOAD absorbs it.
- RAMP:
  - On each frame_tick, each joint moves toward target: if |target − pw| ≤ STEP then pw <= target, else pw <= pw ± STEP.
  - All joints update in the same cycle.
  - Transition evaluated on the updated values: when all four equal target, dwell_cnt <= 0 and go to DWELL.
- DWELL:
  - On each frame_tick, dwell_cnt increments.
  - When dwell_cnt reaches DWELL_FRAMES:
    - If cur_index == pose_count−1: go to IDLE.
    - Else: cur_index + 1, go to LOAD.
  - DWELL_FRAMES = 0 exits on the first tick.
- Commands during playback:
  - cmd_stop in LOAD/RAMP/DWELL: go to IDLE the next cycle; pw_out frozen until the next frame_tick, then passthrough resumes.
  - cmd_store, cmd_clear, cmd_play: err pulse, ignored.
- busy = (state != IDLE), registered. pw_out changes only on frame_tick cycles, so the PWM stage never sees a mid-frame update.
- rst mid-playback: immediate return to reset values on the next edge.

Optional Feature:
SEQ_LOOP_EN:
- Defined: after the last pose's dwell, cur_index wraps to 0 and playback continues (LOAD) until cmd_stop. A 1-pose sequence holds that pose indefinitely.
- Undefined: sequence runs once, then returns to IDLE.

Test Plan:
- Reset, then 3 frame_ticks with live_pw all 40000 -> pw_out all 50000 (clamped); busy=0; pose_count=0.
- Store 2 poses (all 70000; all 55000), play from pw_out all 62500 -> joint rises 200 per tick, reaches 70000 after 38 ticks; holds 25 ticks; falls to 55000 after 75 more ticks; dwell; busy drops, cur_index=1.
- DEPTH=8: 9 cmd_store pulses -> pose_count=8, full=1, err pulse on 9th only; cmd_play with pose_count 0 after cmd_clear -> err, busy stays 0.
- cmd_stop mid-RAMP at pw 66000 -> IDLE next cycle; pw_out stays 66000 until next frame_tick, then follows live_pw.
- Same-cycle cmd_play + cmd_store in IDLE with 1 pose stored -> playback starts, pose_count unchanged, no err.
- SEQ_LOOP_EN defined, 2 poses -> cur_index sequence 0,1,0,1 across 4 dwells; cmd_stop exits; rst mid-RAMP restores all CENTER.
